d8_wb_sel: RTL and testbench

Parametrised writeback-select stage for the d8 core. Decodes the opcode of each accepted instruction, selects its result from the ALU, the B operand, an immediate or a memory load response, and queues it in a small output FIFO with valid/ready handshakes on both sides. It sits between execute and register-file writeback and replaces the purely combinational ALU-output mux with a buffered stage that can absorb writeback stalls and multi-cycle loads.

---
 rtl/d8_pkg.sv | 31 +++
 rtl/d8_wb_fifo.sv | 50 +++++
 rtl/d8_wb_sel.sv | 114 +++++++++++
 tb/tb_d8_wb_sel.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/d8_pkg.sv
// Shared d8 opcode map and writeback source encodings, used by the
// writeback-select stage and the control unit.
package d8_pkg;

    localparam logic [31:0] OP_ALU_LO = 32'h01;
    localparam logic [31:0] OP_ALU_HI = 32'h04;
    localparam logic [31:0] OP_LD_LO  = 32'h05;
    localparam logic [31:0] OP_LD_HI  = 32'h06;
    localparam logic [31:0] OP_LDI    = 32'h07;

    typedef enum logic [1:0] {
        SRC_B   = 2'd0,
        SRC_ALU = 2'd1,
        SRC_MEM = 2'd2,
        SRC_IMM = 2'd3
    } src_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_t;

    // Opcode arrives zero-extended to 32 bits so any OPW up to 32 decodes alike.
    function automatic src_t decode_src(input logic [31:0] op_ext);
        if (op_ext >= OP_ALU_LO && op_ext <= OP_ALU_HI) return SRC_ALU;
        if (op_ext >= OP_LD_LO && op_ext <= OP_LD_HI)   return SRC_MEM;
        if (op_ext == OP_LDI)                           return SRC_IMM;
        return SRC_B;
    endfunction

endpackage

// File: rtl/d8_wb_fifo.sv
// Synchronous FIFO holding packed writeback results; the head is read
// combinationally from storage at the read pointer.
module d8_wb_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign rdata   = mem[rptr];

    // Storage is cleared on reset so the head fields read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/d8_wb_sel.sv
// Writeback-select stage: decodes each accepted op, picks its result source
// and buffers results in a small FIFO; loads park in WAIT until mem_rvalid.
module d8_wb_sel
    import d8_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] imm,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    output logic             out_zero,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = WIDTH + 3;

    wb_state_t        state;
    wb_state_t        state_nx;
    logic             started;
    logic [CW-1:0]    count;
    logic             accept;
    logic             push;
    logic             pop;
    logic [FW-1:0]    push_word;
    logic [FW-1:0]    head_word;
    src_t             dec_src;
    logic [WIDTH-1:0] dec_data;

    assign dec_src = decode_src(32'(op));

    always_comb begin
        case (dec_src)
            SRC_ALU: dec_data = s;
            SRC_IMM: dec_data = imm;
            default: dec_data = b_in;
        endcase
    end

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = started && (state == ST_RUN) && (count < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign busy      = (state == ST_WAIT) || (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            started <= 1'b0;
        end else begin
            state   <= state_nx;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_word = '0;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    if (dec_src == SRC_MEM) begin
                        state_nx = ST_WAIT;
                    end else begin
                        push      = 1'b1;
                        push_word = {dec_data, dec_src, (dec_data == '0)};
                    end
                end
            end
            ST_WAIT: begin
                // A slot was reserved when the load was accepted.
                if (mem_rvalid) begin
                    push      = 1'b1;
                    push_word = {mem_rdata, SRC_MEM, (mem_rdata == '0)};
                    state_nx  = ST_RUN;
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    d8_wb_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head_word),
        .count (count)
    );

    assign out_data = head_word[FW-1:3];
    assign out_src  = head_word[2:1];
    assign out_zero = head_word[0];

endmodule

// File: tb/tb_d8_wb_sel.sv
// Directed checks of d8_wb_sel at WIDTH=8/DEPTH=2, then a randomised
// WIDTH=16/DEPTH=4 run against an in-order result queue.
module tb_d8_wb_sel;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit, depth-2 instance
    logic       in_valid, in_ready, mem_rvalid, out_valid, out_ready, out_zero, busy;
    logic [7:0] op, b_in, s, imm, mem_rdata, out_data;
    logic [1:0] out_src;

    // 16-bit, depth-4 instance
    logic        r_in_valid, r_in_ready, r_rvalid, r_out_valid, r_out_ready, r_out_zero, r_busy;
    logic [7:0]  r_op;
    logic [15:0] r_b, r_s, r_imm, r_rdata, r_out_data;
    logic [1:0]  r_out_src;

    int n_vec = 0;
    int n_err = 0;

    d8_wb_sel #(.WIDTH(8), .OPW(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .b_in(b_in), .s(s), .imm(imm),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_zero(out_zero), .busy(busy)
    );

    d8_wb_sel #(.WIDTH(16), .OPW(8), .DEPTH(4)) dut_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .op(r_op), .b_in(r_b), .s(r_s), .imm(r_imm),
        .mem_rvalid(r_rvalid), .mem_rdata(r_rdata),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
        .out_src(r_out_src), .out_zero(r_out_zero), .busy(r_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [7:0] d, input logic [1:0] src, input logic z);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_src"}, 32'(out_src), 32'(src));
        chk({tag, "_zero"}, 32'(out_zero), 32'(z));
    endtask

    function automatic logic [1:0] exp_src(input logic [7:0] o);
        if (o >= 8'h01 && o <= 8'h04) return 2'd1;
        if (o == 8'h05 || o == 8'h06) return 2'd2;
        if (o == 8'h07)               return 2'd3;
        return 2'd0;
    endfunction

    logic [17:0] exp_q[$];
    logic [17:0] e;
    logic        m_wait;
    int          wait_left;
    int          issued;
    int          cyc;
    logic        acc;
    logic        ld_done;
    logic [1:0]  sw_src;
    logic [15:0] sw_data;

    initial begin
        rst_n = 1'b0;
        in_valid = 0; op = 0; b_in = 0; s = 0; imm = 0; mem_rvalid = 0; mem_rdata = 0; out_ready = 0;
        r_in_valid = 0; r_op = 0; r_b = 0; r_s = 0; r_imm = 0; r_rvalid = 0; r_rdata = 0; r_out_ready = 0;

        // Reset values
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

        // ALU then passthrough, back to back
        out_ready = 1; in_valid = 1; op = 8'h02; s = 8'h5A;
        @(negedge clk);
        chk_head("alu", 8'h5A, 2'd1, 1'b0);
        op = 8'h10; b_in = 8'h33; s = 8'h00;
        @(negedge clk);
        chk_head("pass", 8'h33, 2'd0, 1'b0);
        in_valid = 0;
        @(negedge clk);
        chk("pass_drained", 32'(out_valid), 32'd0);
        chk("pass_idle_busy", 32'(busy), 32'd0);

        // Load with a three-cycle response, zero data
        out_ready = 0; in_valid = 1; op = 8'h05;
        @(negedge clk);
        in_valid = 0;
        chk("ld_in_ready_w1", 32'(in_ready), 32'd0);
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_no_head", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("ld_in_ready_w2", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ld_in_ready_w3", 32'(in_ready), 32'd0);
        mem_rvalid = 1; mem_rdata = 8'h00;
        @(negedge clk);
        chk_head("ld", 8'h00, 2'd2, 1'b1);
        chk("ld_in_ready_back", 32'(in_ready), 32'd1);
        mem_rdata = 8'hAA;
        @(negedge clk);
        mem_rvalid = 0;
        chk_head("ld_spurious_hold", 8'h00, 2'd2, 1'b1);
        out_ready = 1;
        @(negedge clk);
        chk("ld_spurious_nothing", 32'(out_valid), 32'd0);
        chk("ld_spurious_busy", 32'(busy), 32'd0);
        out_ready = 0;

        // Backpressure into a full FIFO, then pop while full
        in_valid = 1; op = 8'h07; imm = 8'h11;
        @(negedge clk);
        chk_head("bp_first", 8'h11, 2'd3, 1'b0);
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        imm = 8'h22;
        @(negedge clk);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        imm = 8'h33;
        @(negedge clk);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk_head("bp_hold", 8'h11, 2'd3, 1'b0);
        out_ready = 1;
        #1 chk("full_pop_ready_same", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk_head("bp_second", 8'h22, 2'd3, 1'b0);
        chk("full_pop_ready_next", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk_head("bp_third", 8'h33, 2'd3, 1'b0);
        in_valid = 0;
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);
        out_ready = 0;

        // Reset while a load is outstanding
        in_valid = 1; op = 8'h07; imm = 8'h44;
        @(negedge clk);
        op = 8'h06;
        @(negedge clk);
        in_valid = 0;
        chk("mid_wait_ready", 32'(in_ready), 32'd0);
        chk_head("mid_head", 8'h44, 2'd3, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_src", 32'(out_src), 32'd0);
        chk("mid_rst_zero", 32'(out_zero), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1; mem_rdata = 8'h77;
        @(negedge clk);
        mem_rvalid = 0;
        chk("mid_late_rvalid_ignored", 32'(out_valid), 32'd0);
        chk("mid_after_busy", 32'(busy), 32'd0);
        chk("mid_after_ready", 32'(in_ready), 32'd1);
        in_valid = 1; op = 8'h01; s = 8'hFF; out_ready = 1;
        @(negedge clk);
        chk_head("mid_alu", 8'hFF, 2'd1, 1'b0);
        in_valid = 0;
        @(negedge clk);

        // Randomised sweep on the 16-bit, depth-4 instance
        m_wait = 0; wait_left = 0; issued = 0; cyc = 0;
        while (issued < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            chk("sw_in_ready", 32'(r_in_ready), 32'(!m_wait && exp_q.size() < 4));
            chk("sw_out_valid", 32'(r_out_valid), 32'(exp_q.size() != 0));
            chk("sw_busy", 32'(r_busy), 32'(m_wait || exp_q.size() != 0));
            chk("sw_count_max", 32'(dut_w16.count <= 3'd4), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("sw_data", 32'(r_out_data), 32'(e[17:2]));
                chk("sw_src", 32'(r_out_src), 32'(e[1:0]));
                chk("sw_zero", 32'(r_out_zero), 32'(e[17:2] == 16'h0));
            end

            r_out_ready = ($urandom_range(0, 3) != 0);
            r_in_valid  = ($urandom_range(0, 3) != 0);
            r_op        = 8'($urandom_range(0, 11));
            r_s         = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            r_b         = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            r_imm       = 16'($urandom);
            r_rdata     = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            r_rvalid    = 1'b0;
            if (m_wait) begin
                if (wait_left == 0) r_rvalid = 1'b1;
                else wait_left--;
            end else begin
                r_rvalid = ($urandom_range(0, 7) == 0);
            end

            acc     = r_in_valid && !m_wait && (exp_q.size() < 4);
            ld_done = m_wait && r_rvalid;
            if (r_out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (ld_done) begin
                exp_q.push_back({r_rdata, 2'd2});
                m_wait = 1'b0;
            end
            if (acc) begin
                issued++;
                sw_src = exp_src(r_op);
                case (sw_src)
                    2'd1:    sw_data = r_s;
                    2'd3:    sw_data = r_imm;
                    default: sw_data = r_b;
                endcase
                if (sw_src == 2'd2) begin
                    m_wait    = 1'b1;
                    wait_left = $urandom_range(0, 3);
                end else begin
                    exp_q.push_back({sw_data, sw_src});
                end
            end
        end
        chk("sw_ops_issued", 32'(issued), 32'd1000);
        r_in_valid = 0; r_rvalid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
